// File: rtl/compare_scheduler.sv
// rtl/compare_scheduler.sv - two-requester scheduler sharing one 16-bit unsigned comparator
// Round-robin grant in IDLE, compare in COMPARE, one-cycle done pulse issued from DONE.
module compare_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        done0,
    output logic        done1,
    output logic        gt,
    output logic        lt,
    output logic        eq,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_last_served;
    logic        r_owner;
    logic [15:0] r_op_a;
    logic [15:0] r_op_b;
    logic        r_done0;
    logic        r_done1;
    logic        r_gt;
    logic        r_lt;
    logic        r_eq;
    logic        w_any_req;
    logic        w_grant;

    assign w_any_req = req0 | req1;

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        w_grant = req1;
        if (req0 && req1) begin
            w_grant = ~r_last_served;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_next_state = COMPARE;
            COMPARE: w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Operands are captured only at the grant edge so later input changes cannot leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_served <= 1'b1;
            r_owner       <= 1'b0;
            r_op_a        <= 16'd0;
            r_op_b        <= 16'd0;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            r_gt          <= 1'b0;
            r_lt          <= 1'b0;
            r_eq          <= 1'b0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_grant;
                        r_op_a  <= w_grant ? a1 : a0;
                        r_op_b  <= w_grant ? b1 : b0;
                    end
                end
                COMPARE: begin
                    r_gt <= (r_op_a > r_op_b);
                    r_lt <= (r_op_a < r_op_b);
                    r_eq <= (r_op_a == r_op_b);
                end
                DONE: begin
                    r_done0       <= ~r_owner;
                    r_done1       <= r_owner;
                    r_last_served <= r_owner;
                end
                default: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                end
            endcase
        end
    end

    assign done0 = r_done0;
    assign done1 = r_done1;
    assign gt    = r_gt;
    assign lt    = r_lt;
    assign eq    = r_eq;
    assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_compare_scheduler.sv
// tb/tb_compare_scheduler.sv - self-checking bench for compare_scheduler
module tb_compare_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [15:0] a0 = 16'd0;
    logic [15:0] b0 = 16'd0;
    logic [15:0] a1 = 16'd0;
    logic [15:0] b1 = 16'd0;
    logic        done0;
    logic        done1;
    logic        gt;
    logic        lt;
    logic        eq;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int ref_last = 1;

    compare_scheduler dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .req1  (req1),
        .a0    (a0),
        .b0    (b0),
        .a1    (a1),
        .b1    (b1),
        .done0 (done0),
        .done1 (done1),
        .gt    (gt),
        .lt    (lt),
        .eq    (eq),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] expect_flags(input logic [15:0] a, input logic [15:0] b);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        return {ia > ib, ia < ib, ia == ib};
    endfunction

    function automatic int pick(input logic r0, input logic r1);
        if (r0 && r1) return (ref_last == 0) ? 1 : 0;
        return r1 ? 1 : 0;
    endfunction

    // Observes edges until a done pulse; owner 2 means both dones were high together.
    task automatic wait_done(input int limit, output int owner, output int cycles);
        bit seen;
        seen   = 0;
        owner  = -1;
        cycles = 0;
        for (int i = 1; i <= limit && !seen; i++) begin
            @(posedge clk);
            #1;
            if (done0 || done1) begin
                seen   = 1;
                cycles = i;
                owner  = (done0 && done1) ? 2 : (done1 ? 1 : 0);
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({done0, done1, gt, lt, eq, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 000000", {done0, done1, gt, lt, eq, busy});
        end
        rst = 1'b0;
        ref_last = 1;
    endtask

    task automatic test_single;
        int owner;
        int cyc;
        req0 = 1'b1; a0 = 16'h1234; b0 = 16'h0FFF;
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy: got %b want 1", busy);
        end
        req0 = 1'b0;
        wait_done(6, owner, cyc);
        n_cmp++;
        if (owner !== 0 || cyc + 1 !== 3) begin
            n_fail++;
            $display("FAIL single_done: owner %0d cycles %0d want owner 0 cycles 3", owner, cyc + 1);
        end
        n_cmp++;
        if ({gt, lt, eq} !== 3'b100) begin
            n_fail++;
            $display("FAIL single_flags: got %b want 100", {gt, lt, eq});
        end
        ref_last = 0;
    endtask

    task automatic test_round_robin;
        int owner;
        int cyc;
        int exp_owner;
        req0 = 1'b1; req1 = 1'b1;
        a0 = 16'd5; b0 = 16'd9; a1 = 16'd7; b1 = 16'd7;
        for (int k = 0; k < 4; k++) begin
            exp_owner = pick(1'b1, 1'b1);
            wait_done(8, owner, cyc);
            n_cmp++;
            if (owner !== exp_owner || cyc !== 3) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: owner %0d cycles %0d want owner %0d cycles 3", k, owner, cyc, exp_owner);
            end
            n_cmp++;
            if ({gt, lt, eq} !== ((exp_owner == 0) ? 3'b010 : 3'b001)) begin
                n_fail++;
                $display("FAIL rr_flags[%0d]: got %b want %b", k, {gt, lt, eq}, (exp_owner == 0) ? 3'b010 : 3'b001);
            end
            ref_last = exp_owner;
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_operand_stability;
        int owner;
        int cyc;
        req1 = 1'b1; a1 = 16'hFFFF; b1 = 16'h0000;
        @(posedge clk);
        #1;
        a1 = 16'h0000; req1 = 1'b0;
        wait_done(6, owner, cyc);
        n_cmp++;
        if (owner !== 1 || {gt, lt, eq} !== 3'b100) begin
            n_fail++;
            $display("FAIL stability: owner %0d flags %b want owner 1 flags 100", owner, {gt, lt, eq});
        end
        ref_last = 1;
    endtask

    task automatic test_boundaries;
        int owner;
        int cyc;
        logic [15:0] va [3];
        logic [15:0] vb [3];
        va[0] = 16'hFFFF; vb[0] = 16'hFFFF;
        va[1] = 16'h0000; vb[1] = 16'h0001;
        va[2] = 16'h0000; vb[2] = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            req0 = 1'b1; a0 = va[k]; b0 = vb[k];
            @(posedge clk);
            #1;
            req0 = 1'b0;
            wait_done(6, owner, cyc);
            n_cmp++;
            if (owner !== 0 || {gt, lt, eq} !== expect_flags(va[k], vb[k])) begin
                n_fail++;
                $display("FAIL boundary[%0d]: owner %0d flags %b want owner 0 flags %b", k, owner, {gt, lt, eq}, expect_flags(va[k], vb[k]));
            end
            ref_last = 0;
        end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if ({gt, lt, eq, busy, done0, done1} !== 6'b001000) begin
            n_fail++;
            $display("FAIL hold_idle: got %b want 001000", {gt, lt, eq, busy, done0, done1});
        end
    endtask

    task automatic test_ignored_req;
        int owner;
        int cyc;
        req0 = 1'b1; a0 = 16'd3; b0 = 16'd1;
        @(posedge clk);
        #1;
        req0 = 1'b0; req1 = 1'b1;
        @(posedge clk);
        #1;
        req1 = 1'b0;
        wait_done(4, owner, cyc);
        n_cmp++;
        if (owner !== 0) begin
            n_fail++;
            $display("FAIL ignored_first: owner %0d want 0", owner);
        end
        ref_last = 0;
        wait_done(6, owner, cyc);
        n_cmp++;
        if (owner !== -1) begin
            n_fail++;
            $display("FAIL ignored_req: owner %0d want none", owner);
        end
    endtask

    task automatic test_random;
        int owner;
        int cyc;
        int exp_owner;
        logic r0;
        logic r1;
        logic [2:0] exp_f;
        for (int k = 0; k < 40; k++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            a0 = 16'($urandom); b0 = (k % 5 == 0) ? a0 : 16'($urandom);
            a1 = 16'($urandom); b1 = (k % 7 == 0) ? a1 : 16'($urandom);
            req0 = r0; req1 = r1;
            exp_owner = pick(r0, r1);
            exp_f = (exp_owner == 1) ? expect_flags(a1, b1) : expect_flags(a0, b0);
            @(posedge clk);
            #1;
            req0 = 1'b0; req1 = 1'b0;
            a0 = 16'($urandom); a1 = 16'($urandom);
            wait_done(6, owner, cyc);
            n_cmp++;
            if (owner !== exp_owner || cyc + 1 !== 3 || {gt, lt, eq} !== exp_f) begin
                n_fail++;
                $display("FAIL random[%0d]: owner %0d cyc %0d flags %b want owner %0d cyc 3 flags %b",
                         k, owner, cyc + 1, {gt, lt, eq}, exp_owner, exp_f);
            end
            ref_last = exp_owner;
        end
    endtask

    task automatic test_reset_mid_op;
        int owner;
        int cyc;
        req0 = 1'b1; a0 = 16'd9; b0 = 16'd2;
        @(posedge clk);
        #2;
        req0 = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({done0, done1, gt, lt, eq, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b want 000000", {done0, done1, gt, lt, eq, busy});
        end
        wait_done(3, owner, cyc);
        n_cmp++;
        if (owner !== -1) begin
            n_fail++;
            $display("FAIL reset_abort: owner %0d want none", owner);
        end
        rst = 1'b0;
        ref_last = 1;
        req0 = 1'b1; req1 = 1'b1;
        a0 = 16'd1; b0 = 16'd1; a1 = 16'd2; b1 = 16'd1;
        exp_owner_check: begin
            wait_done(6, owner, cyc);
            n_cmp++;
            if (owner !== pick(1'b1, 1'b1) || {gt, lt, eq} !== 3'b001) begin
                n_fail++;
                $display("FAIL reset_first_tie: owner %0d flags %b want owner 0 flags 001", owner, {gt, lt, eq});
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        ref_last = 0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_operand_stability;
        test_boundaries;
        test_ignored_req;
        test_random;
        test_reset_mid_op;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/compare_scheduler.md
COMPARE_SCHEDULER -- requirements
Module: compare_scheduler

Interface
REQ-001 The block SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 req0, req1  in  1  level request from requester 0 and requester 1.
REQ-004 a0, b0  in  16  unsigned operands of requester 0; a1, b1  in  16  unsigned operands of requester 1.
REQ-005 done0, done1  out  1  one-cycle completion pulse to requester 0 and requester 1.
REQ-006 gt, lt, eq  out  1  registered comparison result of the last completed request (a>b, a<b, a==b).
REQ-007 busy  out  1  high whenever the state is not IDLE.
REQ-008 There SHALL be one clock, and reset SHALL be asynchronous and active-high.

Function
REQ-009 The block SHALL time-share one 16-bit unsigned magnitude comparator between the two requesters.
REQ-010 FSM states SHALL be IDLE, COMPARE and DONE, with IDLE as the reset state.
REQ-011 IDLE SHALL stay in IDLE while req0=req1=0.
REQ-012 IDLE with any req SHALL:
- select the owner;
- latch the owner's a,b into internal op_a, op_b and record the owner;
- go to COMPARE.
REQ-013 Arbitration SHALL be round-robin using a last_served pointer:
- one requester active: grant it;
- both active: grant the requester not equal to last_served.
REQ-014 COMPARE SHALL register gt=(op_a>op_b), lt=(op_a<op_b), eq=(op_a==op_b), then go to DONE.
REQ-015 Exactly one of gt/lt/eq SHALL be high after any completed comparison.
REQ-016 DONE SHALL:
- assert done of the owner only, for exactly one cycle;
- set last_served to the owner;
- return to IDLE.
REQ-017 Latency: a req sampled high in IDLE at edge k SHALL produce the owner's done high during the cycle following edge k+2, so back-to-back service takes 3 cycles per request.
REQ-018 Operands SHALL be sampled only at the grant edge; operand changes after the grant SHALL NOT affect the result.
REQ-019 A req that is still high in IDLE after its done SHALL be treated as a new request, subject to REQ-013.
REQ-020 Req changes during COMPARE or DONE SHALL be ignored; a req dropped before IDLE samples it SHALL produce no service.
REQ-021 gt/lt/eq SHALL hold their value from DONE until the next COMPARE cycle overwrites them.
REQ-022 done0 and done1 SHALL never be high in the same cycle.
REQ-023 busy SHALL be low only in IDLE.
REQ-024 Operands a0=b0=0 and a0=b0=16'hFFFF SHALL yield eq=1.
REQ-025 16'hFFFF vs 16'h0000 SHALL yield gt=1, with no signed interpretation.

Reset
REQ-026 On rst=1, the block SHALL immediately, without waiting for clk:
- set the state to IDLE;
- clear done0, done1, gt, lt, eq and busy to 0;
- set last_served=1, so requester 0 wins the first tie;
- clear op_a, op_b and owner to 0.
REQ-027 Reset asserted in COMPARE or DONE SHALL abort the transaction with no done pulse.
REQ-028 After rst falls, the first rising edge SHALL evaluate requests as in IDLE.

Verification
REQ-029 Single request: reset, then req0=1, a0=16'h1234, b0=16'h0FFF -> done0 pulses on the 3rd cycle after grant, gt=1, lt=0, eq=0, done1 stays 0.
REQ-030 Tie and round-robin: req0=req1=1 held, a0=5, b0=9, a1=7, b1=7 ->
- service order 0,1,0,1;
- results: lt=1 on done0, eq=1 on done1;
- done never overlaps.
REQ-031 Operand stability: grant req1 with a1=16'hFFFF, b1=0, then change a1 to 0 during COMPARE -> done1 with gt=1.
REQ-032 Boundaries: a0=b0=16'hFFFF -> eq=1; a0=0, b0=16'h0001 -> lt=1; gt/lt/eq hold across a following IDLE period.
REQ-033 Reset mid-operation: assert rst during COMPARE -> outputs 0 asynchronously, no done; after release, req0=req1=1 -> requester 0 is served first.
